rca_result_checker: RTL and testbench

//  Downstream self-checking stage for the 32-bit ripple-carry adder. It latches each operand set
//  {A,B,Cin} presented to the adder and computes the golden {Cout,S} = A+B+Cin. After a fixed

---
 rtl/rca_result_checker_pkg.sv | 23 ++
 rtl/rca_result_checker_sat_counter.sv | 23 ++
 rtl/rca_result_checker.sv | 172 +++++++++++++++++
 tb/tb_rca_result_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_result_checker_pkg.sv
// Shared types and defaults for the ripple-carry adder result checker.
package rca_result_checker_pkg;

   // Default operand/sum width, matching the adder under test.
   localparam int unsigned RCA_WIDTH  = 32;

   // Default settle window between operand accept and S/Cout sample.
   localparam int unsigned RCA_SETTLE = 2;

   // Default pass/fail counter width.
   localparam int unsigned RCA_CNT_W  = 16;

   // Width of the settle down-counter; covers the legal 1..15 window.
   localparam int unsigned RCA_SETTLE_W = 4;

   // Checker sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2
   } state_t;

endpackage

// File: rtl/rca_result_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   // Clear has priority over increment; increment stops at the saturation value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/rca_result_checker.sv
// Self-checking stage for the ripple-carry adder: latches each operand set,
// computes the golden sum, samples the adder after a settle window, compares,
// counts passes/fails and captures the first failing vector.
module rca_result_checker
   import rca_result_checker_pkg::*;
#(
   parameter int unsigned WIDTH         = RCA_WIDTH,
   parameter int unsigned SETTLE_CYCLES = RCA_SETTLE,
   parameter int unsigned CNT_W         = RCA_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [WIDTH-1:0] S,
   input  logic             Cout,
   output logic             result_valid,
   output logic             mismatch,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             err_sticky,
   output logic [WIDTH-1:0] err_a,
   output logic [WIDTH-1:0] err_b,
   output logic [WIDTH:0]   err_s,
   output logic             overrun
);

   localparam logic [RCA_SETTLE_W-1:0] SETTLE_LOAD = RCA_SETTLE_W'(SETTLE_CYCLES - 1);

   state_t                  state_q;
   state_t                  state_d;
   logic [RCA_SETTLE_W-1:0] cnt_q;
   logic [WIDTH-1:0]        a_q;
   logic [WIDTH-1:0]        b_q;
   logic [WIDTH:0]          gold_q;
   logic [WIDTH:0]          obs_q;
   logic                    mis_q;
   logic                    accept;
   logic                    sample;
   logic                    pass_inc;
   logic                    fail_inc;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode plus handshake and strobe outputs.
   always_comb begin
      state_d      = state_q;
      op_ready     = 1'b0;
      result_valid = 1'b0;
      accept       = 1'b0;
      sample       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) begin
               accept  = 1'b1;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               sample  = 1'b1;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            op_ready     = 1'b1;
            result_valid = 1'b1;
            if (op_valid) begin
               accept  = 1'b1;
               state_d = ST_SETTLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Operand latch, golden sum and settle countdown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         gold_q <= '0;
         cnt_q  <= '0;
      end else if (accept) begin
         a_q    <= A;
         b_q    <= B;
         gold_q <= {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
         cnt_q  <= SETTLE_LOAD;
      end else if ((state_q == ST_SETTLE) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - {{(RCA_SETTLE_W-1){1'b0}}, 1'b1};
      end
   end

   // Sample the adder at the end of the settle window and register the verdict.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         obs_q <= '0;
         mis_q <= 1'b0;
      end else if (sample) begin
         obs_q <= {Cout, S};
         mis_q <= ({Cout, S} != gold_q);
      end
   end

   assign mismatch = result_valid & mis_q;
   assign pass_inc = result_valid & ~mis_q;
   assign fail_inc = result_valid &  mis_q;

   // First-mismatch capture; later mismatches leave the capture alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sticky <= 1'b0;
         err_a      <= '0;
         err_b      <= '0;
         err_s      <= '0;
      end else if (clear) begin
         err_sticky <= 1'b0;
         err_a      <= '0;
         err_b      <= '0;
         err_s      <= '0;
      end else if (fail_inc && !err_sticky) begin
         err_sticky <= 1'b1;
         err_a      <= a_q;
         err_b      <= b_q;
         err_s      <= obs_q;
      end
   end

   // Sticky flag for operand sets offered while the checker is busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (clear) begin
         overrun <= 1'b0;
      end else if (op_valid && !op_ready) begin
         overrun <= 1'b1;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
      .clk (clk),
      .rst (rst),
      .inc (pass_inc),
      .clr (clear),
      .q   (pass_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
      .clk (clk),
      .rst (rst),
      .inc (fail_inc),
      .clr (clear),
      .q   (fail_count)
   );

endmodule

// File: tb/tb_rca_result_checker.sv
// Scoreboard bench for rca_result_checker with a behavioural adder whose
// outputs can be corrupted on demand.
module tb_rca_result_checker;

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 4;

   logic          clk;
   logic          rst;
   logic          clear;
   logic          op_valid;
   logic          op_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Cin;
   logic [W-1:0]  S;
   logic          Cout;
   logic          result_valid;
   logic          mismatch;
   logic [CW-1:0] pass_count;
   logic [CW-1:0] fail_count;
   logic          err_sticky;
   logic [W-1:0]  err_a;
   logic [W-1:0]  err_b;
   logic [W:0]    err_s;
   logic          overrun;

   logic          f_cout;
   logic [W-1:0]  f_s;

   int tests = 0;
   int fails = 0;
   logic exp_q[$];

   rca_result_checker #(.WIDTH(W), .SETTLE_CYCLES(2), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .A            (A),
      .B            (B),
      .Cin          (Cin),
      .S            (S),
      .Cout         (Cout),
      .result_valid (result_valid),
      .mismatch     (mismatch),
      .pass_count   (pass_count),
      .fail_count   (fail_count),
      .err_sticky   (err_sticky),
      .err_a        (err_a),
      .err_b        (err_b),
      .err_s        (err_s),
      .overrun      (overrun)
   );

   // Adder under test: correct sum with optional fault masks.
   assign {Cout, S} = ({1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin}) ^ {f_cout, f_s};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every result pulse must match the oldest expected verdict.
   always @(negedge clk) begin
      if (!rst) begin
         if (result_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_result: got result_valid=1 expected none");
            end else begin
               chk("mismatch", 64'(mismatch), 64'(exp_q.pop_front()));
            end
         end else if (mismatch) begin
            chk("mismatch_idle", 64'(mismatch), 64'd0);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic fc, input logic [W-1:0] fs, input logic push,
                        input logic exp_mis);
      int n = 0;
      while (!op_ready && n < 50) begin
         step();
         n++;
      end
      if (!op_ready) chk("issue_timeout", 64'(op_ready), 64'd1);
      A = a; B = b; Cin = cin; f_cout = fc; f_s = fs;
      op_valid = 1'b1;
      if (push) exp_q.push_back(exp_mis);
      step();
      op_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      step();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; op_valid = 1'b0;
      A = '0; B = '0; Cin = 1'b0; f_cout = 1'b0; f_s = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Reset state
      chk("rst_op_ready", 64'(op_ready), 64'd1);
      chk("rst_result_valid", 64'(result_valid), 64'd0);
      chk("rst_pass", 64'(pass_count), 64'd0);
      chk("rst_fail", 64'(fail_count), 64'd0);
      chk("rst_sticky", 64'(err_sticky), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk("rst_err_s", 64'(err_s), 64'd0);

      // Sweep A=0..9, B=10
      for (int i = 0; i < 10; i++) issue(W'(i), 32'd10, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      drain();
      chk("sweep_pass", 64'(pass_count), 64'd10);
      chk("sweep_fail", 64'(fail_count), 64'd0);
      chk("sweep_overrun", 64'(overrun), 64'd0);

      // Wrap-around: correct, then Cout forced low
      issue(32'hFFFF_FFFC, 32'd3, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      drain();
      chk("wrap_pass", 64'(pass_count), 64'd11);
      issue(32'hFFFF_FFFC, 32'd3, 1'b1, 1'b1, '0, 1'b1, 1'b1);
      drain();
      chk("wrap_fail", 64'(fail_count), 64'd1);
      chk("wrap_sticky", 64'(err_sticky), 64'd1);
      chk("wrap_err_s", 64'(err_s), 64'h0_0000_0000);
      chk("wrap_err_a", 64'(err_a), 64'hFFFF_FFFC);
      chk("wrap_err_b", 64'(err_b), 64'd3);
      pulse_clear();
      chk("clr_pass", 64'(pass_count), 64'd0);
      chk("clr_sticky", 64'(err_sticky), 64'd0);

      // First-error hold: faults on vectors 3 and 5
      for (int i = 1; i <= 6; i++) begin
         logic fault;
         fault = (i == 3) || (i == 5);
         issue(W'(100 + i), W'(200 + i), 1'b0, 1'b0, fault ? W'(i) : '0, 1'b1, fault);
      end
      drain();
      chk("hold_fail", 64'(fail_count), 64'd2);
      chk("hold_pass", 64'(pass_count), 64'd4);
      chk("hold_err_a", 64'(err_a), 64'd103);
      chk("hold_err_b", 64'(err_b), 64'd203);
      chk("hold_err_s", 64'(err_s), 64'h131);
      chk("hold_sticky", 64'(err_sticky), 64'd1);
      pulse_clear();
      chk("hclr_sticky", 64'(err_sticky), 64'd0);
      chk("hclr_err_a", 64'(err_a), 64'd0);
      chk("hclr_err_b", 64'(err_b), 64'd0);
      chk("hclr_err_s", 64'(err_s), 64'd0);
      chk("hclr_fail", 64'(fail_count), 64'd0);

      // Overrun: op_valid held for 12 cycles -> 4 accepted checks
      A = 32'd7; B = 32'd8; Cin = 1'b0; f_cout = 1'b0; f_s = '0;
      for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
      op_valid = 1'b1;
      repeat (12) step();
      op_valid = 1'b0;
      drain();
      chk("ovr_pass", 64'(pass_count), 64'd4);
      chk("ovr_flag", 64'(overrun), 64'd1);
      pulse_clear();
      chk("ovr_clr", 64'(overrun), 64'd0);

      // Reset mid-settle
      issue(32'd1, 32'd2, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      drain();
      chk("pre_rst_pass", 64'(pass_count), 64'd1);
      issue(32'd5, 32'd6, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      chk("mid_rst_rv", 64'(result_valid), 64'd0);
      chk("mid_rst_ready", 64'(op_ready), 64'd1);
      chk("mid_rst_pass", 64'(pass_count), 64'd0);
      rst = 1'b0;
      repeat (4) step();
      chk("post_rst_pass", 64'(pass_count), 64'd0);
      issue(32'd5, 32'd6, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      drain();
      chk("post_rst_run", 64'(pass_count), 64'd1);

      // Saturation at 4'hF, then clear coincident with CHECK
      pulse_clear();
      for (int i = 0; i < 20; i++) issue(W'(i * 3), W'(i), 1'b1, 1'b0, '0, 1'b1, 1'b0);
      drain();
      chk("sat_pass", 64'(pass_count), 64'hF);
      issue(32'd9, 32'd9, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      begin
         int n = 0;
         while (!result_valid && n < 20) begin
            step();
            n++;
         end
         chk("cc_rv_seen", 64'(result_valid), 64'd1);
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("cc_pass", 64'(pass_count), 64'd0);
      chk("cc_fail", 64'(fail_count), 64'd0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
